// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and the instruction cache it feeds.
package fetch_pkg;

  localparam int IF_ADDR_WIDTH = 16;
  localparam int IF_DATA_WIDTH = 16;
  localparam logic [IF_ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {pc, instruction} pairs until decode accepts them.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [AW-1:0]              push_pc,
  input  logic [DW-1:0]              push_instr,
  input  logic                       pop,
  output logic [AW-1:0]              head_pc,
  output logic [DW-1:0]              head_instr,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [DW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign do_push = push && (count_reg != FULL_COUNT);
  assign do_pop  = pop && (count_reg != '0);

  // Storage is reset so an empty queue presents zeros at its head after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (do_push && !clear) begin
      pc_mem[wr_ptr_reg]    <= push_pc;
      instr_mem[wr_ptr_reg] <= push_instr;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];
  assign valid      = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, requests words from the instruction cache, waits out
// refills, honours branch redirects and queues instructions for decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = IF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = IF_DATA_WIDTH,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] ic_address,
  output logic                  ic_read,
  output logic                  ic_flush,
  output logic [15:0]           ic_instruction_count,
  input  logic                  ic_hit,
  input  logic [DATA_WIDTH-1:0] ic_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0] id_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  fetch_state_t          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [15:0]           retired_reg, retired_next;
  logic [CW-1:0]         q_count;
  logic                  push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ic_read      = 1'b0;
    ic_flush     = redirect_valid;
    case (state_reg)
      BOOT:    state_next = FETCH;
      // The full check ignores a same-cycle pop so id_ready never reaches ic_read.
      FETCH:   ic_read = (q_count != FULL_COUNT) && !redirect_valid;
      MISS:    ic_read = !redirect_valid;
      default: state_next = BOOT;
    endcase
    push = ic_read && ic_hit;
    if (push) begin
      pc_next    = pc_reg + 1'b1;
      state_next = FETCH;
    end else if (ic_read) begin
      state_next = MISS;
    end
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = FETCH;
    end
    retired_next = retired_reg + (push ? 16'd1 : 16'd0);
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH),
    .AW   (ADDR_WIDTH),
    .DW   (DATA_WIDTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_pc   (pc_reg),
    .push_instr(ic_data),
    .pop       (id_ready),
    .head_pc   (id_pc),
    .head_instr(id_instruction),
    .valid     (id_valid),
    .count     (q_count)
  );

  assign ic_address           = pc_reg;
  assign ic_instruction_count = retired_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a second instance starts at PC FFFF
// to exercise PC wrap.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_hit;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;

  logic [15:0] ic_address, ic_instruction_count, id_instruction, id_pc, ic_data;
  logic        ic_read, ic_flush, id_valid;

  logic [15:0] w_address, w_count, w_instr, w_pc, w_data;
  logic        w_read, w_flush, w_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Cache model: read data is a fixed function of the requested address.
  assign ic_data = 16'hA000 + ic_address;
  assign w_data  = 16'hA000 + w_address;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .ic_address(ic_address), .ic_read(ic_read), .ic_flush(ic_flush),
    .ic_instruction_count(ic_instruction_count),
    .ic_hit(ic_hit), .ic_data(ic_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instruction(id_instruction), .id_pc(id_pc)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset),
    .ic_address(w_address), .ic_read(w_read), .ic_flush(w_flush),
    .ic_instruction_count(w_count),
    .ic_hit(ic_hit), .ic_data(w_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(w_valid), .id_ready(id_ready),
    .id_instruction(w_instr), .id_pc(w_pc)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; ic_hit = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;

    // Reset state, before any clock edge
    #2;
    check("rst_read",  ic_read, 0);
    check("rst_flush", ic_flush, 0);
    check("rst_valid", id_valid, 0);
    check("rst_count", ic_instruction_count, 0);
    check("rst_instr", id_instruction, 0);
    check("rst_pc",    id_pc, 0);
    check("rst_addr",  ic_address, 16'h0000);
    check("rst_waddr", w_address, 16'hFFFF);

    // Always-hit streaming
    @(negedge clk); reset = 1'b0; #1;
    check("boot_read", ic_read, 0);
    tick();
    check("s0_read", ic_read, 1);
    check("s0_addr", ic_address, 16'h0000);
    check("s0_valid", id_valid, 0);
    tick();
    check("s1_valid", id_valid, 1);
    check("s1_pc", id_pc, 16'h0000);
    check("s1_instr", id_instruction, 16'hA000);
    check("s1_count", ic_instruction_count, 16'd1);
    check("w1_pc", w_pc, 16'hFFFF);
    check("w1_instr", w_instr, 16'h9FFF);
    tick();
    check("s2_pc", id_pc, 16'h0001);
    check("s2_instr", id_instruction, 16'hA001);
    check("s2_count", ic_instruction_count, 16'd2);
    check("w2_pc", w_pc, 16'h0000);
    check("w2_instr", w_instr, 16'hA000);
    tick();
    check("s3_pc", id_pc, 16'h0002);
    check("s3_instr", id_instruction, 16'hA002);
    check("s3_count", ic_instruction_count, 16'd3);

    // Cold miss at pc 0; data returns in the sixth cycle of the request
    ic_hit = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("miss%0d_read", i), ic_read, 1);
      check($sformatf("miss%0d_addr", i), ic_address, 16'h0000);
      check($sformatf("miss%0d_valid", i), id_valid, 0);
      if (i == 5) ic_hit = 1'b1;
      tick();
    end
    check("refill_pc", id_pc, 16'h0000);
    check("refill_instr", id_instruction, 16'hA000);
    check("refill_count", ic_instruction_count, 16'd1);
    check("refill_addr", ic_address, 16'h0001);
    check("refill_read", ic_read, 1);
    tick();
    check("after_pc", id_pc, 16'h0001);
    check("after_count", ic_instruction_count, 16'd2);

    // Backpressure: two pushes then stall
    id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("bp1_count", ic_instruction_count, 16'd1);
    tick();
    check("bp2_read", ic_read, 0);
    check("bp2_addr", ic_address, 16'h0002);
    tick();
    check("bp3_read", ic_read, 0);
    check("bp3_addr", ic_address, 16'h0002);
    check("bp3_pc", id_pc, 16'h0000);
    check("bp3_count", ic_instruction_count, 16'd2);
    id_ready = 1'b1; #1;
    check("bp_full_read", ic_read, 0);
    tick();
    check("drain1_pc", id_pc, 16'h0001);
    check("drain1_instr", id_instruction, 16'hA001);
    check("drain1_read", ic_read, 1);
    tick();
    check("drain2_pc", id_pc, 16'h0002);
    check("drain2_count", ic_instruction_count, 16'd3);

    // Redirect during the third miss cycle
    ic_hit = 1'b0;
    do_reset();
    tick();
    check("rm1_flush", ic_flush, 0);
    tick();
    check("rm2_flush", ic_flush, 0);
    check("rm2_read", ic_read, 1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
    check("rm3_flush", ic_flush, 1);
    check("rm3_read", ic_read, 0);
    tick();
    redirect_valid = 1'b0; #1;
    check("rd_flush", ic_flush, 0);
    check("rd_read", ic_read, 1);
    check("rd_addr", ic_address, 16'h0040);
    check("rd_valid", id_valid, 0);
    ic_hit = 1'b1;
    tick();
    check("rd_pc", id_pc, 16'h0040);
    check("rd_instr", id_instruction, 16'hA040);
    check("rd_count", ic_instruction_count, 16'd1);

    // Redirect coincident with a hit: the hit is dropped
    redirect_valid = 1'b1; redirect_pc = 16'h0100; #1;
    check("rh_read", ic_read, 0);
    tick();
    redirect_valid = 1'b0; #1;
    check("rh_valid", id_valid, 0);
    check("rh_count", ic_instruction_count, 16'd1);
    check("rh_addr", ic_address, 16'h0100);
    tick();
    check("rh_pc", id_pc, 16'h0100);
    check("rh_instr", id_instruction, 16'hA100);
    check("rh_count2", ic_instruction_count, 16'd2);

    // Asynchronous reset in the middle of a miss
    id_ready = 1'b0; ic_hit = 1'b1;
    do_reset();
    tick();
    tick();
    ic_hit = 1'b0; #1;
    tick();
    tick();
    check("am_valid", id_valid, 1);
    check("am_addr", ic_address, 16'h0001);
    check("am_read", ic_read, 1);
    check("am_count", ic_instruction_count, 16'd1);
    #2 reset = 1'b1; #1;
    check("ar_read", ic_read, 0);
    check("ar_flush", ic_flush, 0);
    check("ar_valid", id_valid, 0);
    check("ar_addr", ic_address, 16'h0000);
    check("ar_count", ic_instruction_count, 16'd0);
    check("ar_instr", id_instruction, 16'h0000);
    check("ar_pc", id_pc, 16'h0000);
    @(negedge clk); reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
